sc_reg_scroll_bank: RTL and testbench
=====================================

# sc_reg_scroll_bank

Parametrised register bank of REG_DEPTH rows, each REG_WIDTH bits, with synchronous random write, whole-bank scroll (row i moves to row i+1, new row enters at row 0) and optional rotate. Successor to the single combinational reset register: clocked storage, addressed access, scroll counter and spill-out of the row leaving the bank. Sits between the game controller and the road/obstacle renderer; holds the visible road matrix scrolled once per game tick.

## Interface
- REG_WIDTH, 8, bits per row
- REG_DEPTH, 8, number of rows (≥2)
- ADDR_WIDTH, 3, address width; 2^ADDR_WIDTH ≥ REG_DEPTH
- CNT_WIDTH, 8, scroll counter width

- SC_RegSCROLL_CLOCK_50  in  1  system clock, all state on rising edge
- SC_RegSCROLL_RESET_InLow  in  1  reset, synchronous, active-low
- SC_RegSCROLL_clear_InHigh  in  1  synchronous clear of all rows and counter
- SC_RegSCROLL_op_InBUS  in  2  operation: 00 hold, 01 write, 10 scroll, 11 rotate
- SC_RegSCROLL_wraddr_InBUS  in  ADDR_WIDTH  write row address
- SC_RegSCROLL_data_InBUS  in  REG_WIDTH  write data / new row 0 on scroll
- SC_RegSCROLL_rdaddr_InBUS  in  ADDR_WIDTH  read row address
- SC_RegSCROLL_rddata_OutBUS  out  REG_WIDTH  registered read data
- SC_RegSCROLL_spill_OutBUS  out  REG_WIDTH  row pushed out of row REG_DEPTH-1 on scroll
- SC_RegSCROLL_spill_valid_OutHigh  out  1  one-cycle strobe qualifying spill
- SC_RegSCROLL_count_OutBUS  out  CNT_WIDTH  number of scroll/rotate ops, wraps

## Operation
- Reset low at an edge: all rows, rddata, spill, spill_valid, count ← 0. Reset overrides clear and op.
- Priority: reset > clear > op. Clear: all rows and count ← 0, spill_valid ← 0, rddata ← 0.
- Hold (00): no state change except rddata update; spill_valid ← 0.
- Write (01): row[wraddr] ← data. wraddr ≥ REG_DEPTH: write ignored, no other effect.
- Scroll (10): row[i] ← row[i-1] for i=1..REG_DEPTH-1; row[0] ← data; spill ← old row[REG_DEPTH-1]; spill_valid ← 1; count ← count+1 mod 2^CNT_WIDTH.
- Rotate (11): row[i] ← row[i-1]; row[0] ← old row[REG_DEPTH-1]; data ignored; spill unchanged; spill_valid ← 0; count ← count+1.
- Read: rddata ← row[rdaddr] sampled from pre-edge contents every cycle; rdaddr ≥ REG_DEPTH returns 0.
- spill holds last value until next scroll; only spill_valid pulses.

## Timing
- Write/scroll/rotate: effect visible in internal rows one edge after op sampled.
- Read latency 1 cycle; read of a row written in the same cycle returns old value, new value one cycle later.
- Read of any row in the cycle of a scroll returns pre-scroll contents.
- spill_valid high exactly the cycle after the scroll edge; back-to-back scrolls keep it high continuously, each cycle carrying a new row.
- count wraps 2^CNT_WIDTH-1 → 0 with no flag.
- Reset or clear asserted mid-sequence: takes effect at that edge; the op in that cycle is discarded.

## Configuration
- SC_REGSCROLL_ROTATE_EN defined: op 11 rotates as above.
- Not defined: op 11 behaves as hold (no row change, count unchanged, spill_valid ← 0).

## Structure
- Package sc_regscroll_pkg: op encoding constants (OP_HOLD, OP_WRITE, OP_SCROLL, OP_ROTATE).
- Sub-module sc_regscroll_row: one REG_WIDTH register with sync reset, clear, load-enable and 2:1 next-value mux (write data vs. previous row); instantiated REG_DEPTH times via generate.
- Top holds address decode, row-0 source mux, read mux, spill and counter registers.

## Test plan
- Reset low 2 cycles with op=01 data=0xFF → all rows, rddata, count, spill 0, spill_valid 0.
- Write 0x11..0x88 to rows 0..7, read rows 0..7 → rddata 0x11..0x88, each one cycle after rdaddr.
- Scroll with data=0xA5 → row0=0xA5, row1=0x11, row7=0x77, spill=0x88, spill_valid one cycle, count=1.
- Rotate (macro on) on bank 0x11..0x88 → row0=0x88, row1=0x11, spill_valid 0, count+1; macro off → bank unchanged, count unchanged.
- 256 scrolls with CNT_WIDTH=8 → count returns to 0; clear asserted with op=10 → rows 0, count 0, spill_valid 0.
- Write to wraddr=9 with REG_DEPTH=8, ADDR_WIDTH=4 → no row changes; rdaddr=9 → rddata 0.

Source files
------------

// File: rtl/sc_regscroll_pkg.sv
// rtl/sc_regscroll_pkg.sv - operation encodings shared by the scroll bank and its bench
package sc_regscroll_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SCROLL = 2'b10;
    localparam logic [1:0] OP_ROTATE = 2'b11;

endpackage

// File: rtl/sc_regscroll_row.sv
// rtl/sc_regscroll_row.sv - one bank row: sync reset, clear, load-enable, data/previous-row mux
module sc_regscroll_row #(
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 sel_data_i,
    input  logic [REG_WIDTH-1:0] data_i,
    input  logic [REG_WIDTH-1:0] prev_i,
    output logic [REG_WIDTH-1:0] q_o
);

    logic [REG_WIDTH-1:0] row_q;
    logic [REG_WIDTH-1:0] row_d;

    // Next value is either external data (write / new row 0) or the neighbouring row (shift)
    always_comb begin
        row_d = sel_data_i ? data_i : prev_i;
    end

    // Row storage; reset and clear both zero the row and win over a load
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            row_q <= '0;
        end else if (clear_i) begin
            row_q <= '0;
        end else if (load_i) begin
            row_q <= row_d;
        end
    end

    assign q_o = row_q;

endmodule

// File: rtl/sc_reg_scroll_bank.sv
// rtl/sc_reg_scroll_bank.sv - scrolling register bank top; op 11 rotates only with SC_REGSCROLL_ROTATE_EN
module sc_reg_scroll_bank
    import sc_regscroll_pkg::*;
#(
    parameter int REG_WIDTH  = 8,
    parameter int REG_DEPTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  SC_RegSCROLL_CLOCK_50,
    input  logic                  SC_RegSCROLL_RESET_InLow,
    input  logic                  SC_RegSCROLL_clear_InHigh,
    input  logic [1:0]            SC_RegSCROLL_op_InBUS,
    input  logic [ADDR_WIDTH-1:0] SC_RegSCROLL_wraddr_InBUS,
    input  logic [REG_WIDTH-1:0]  SC_RegSCROLL_data_InBUS,
    input  logic [ADDR_WIDTH-1:0] SC_RegSCROLL_rdaddr_InBUS,
    output logic [REG_WIDTH-1:0]  SC_RegSCROLL_rddata_OutBUS,
    output logic [REG_WIDTH-1:0]  SC_RegSCROLL_spill_OutBUS,
    output logic                  SC_RegSCROLL_spill_valid_OutHigh,
    output logic [CNT_WIDTH-1:0]  SC_RegSCROLL_count_OutBUS
);

    logic                 op_write;
    logic                 op_scroll;
    logic                 op_rotate_raw;
    logic                 op_rotate;
    logic                 row_load   [REG_DEPTH];
    logic                 row_sel    [REG_DEPTH];
    logic [REG_WIDTH-1:0] row_vals   [REG_DEPTH];
    logic [REG_WIDTH-1:0] rddata_d;
    logic [REG_WIDTH-1:0] rddata_q;
    logic [REG_WIDTH-1:0] spill_q;
    logic                 spill_valid_q;
    logic [CNT_WIDTH-1:0] count_q;

    // Decode the operation code into one-hot strobes
    always_comb begin
        op_write      = 1'b0;
        op_scroll     = 1'b0;
        op_rotate_raw = 1'b0;
        case (SC_RegSCROLL_op_InBUS)
            OP_HOLD:   ;
            OP_WRITE:  op_write      = 1'b1;
            OP_SCROLL: op_scroll     = 1'b1;
            OP_ROTATE: op_rotate_raw = 1'b1;
            default:   ;
        endcase
    end

`ifdef SC_REGSCROLL_ROTATE_EN
    assign op_rotate = op_rotate_raw;
`else
    // Without rotate support op 11 degenerates to hold
    logic unused_rotate;
    assign unused_rotate = op_rotate_raw;
    assign op_rotate     = 1'b0;
`endif

    // Per-row load enables and source selects; out-of-range write addresses match no row
    always_comb begin
        for (int i = 0; i < REG_DEPTH; i++) begin
            row_load[i] = op_scroll | op_rotate |
                          (op_write && (SC_RegSCROLL_wraddr_InBUS == ADDR_WIDTH'(i)));
            row_sel[i]  = op_write | ((i == 0) && op_scroll);
        end
    end

    // Row chain: row 0's shift source is the last row, which gives rotate for free
    for (genvar g = 0; g < REG_DEPTH; g++) begin : g_row
        logic [REG_WIDTH-1:0] prev;
        if (g == 0) begin : g_first
            assign prev = row_vals[REG_DEPTH-1];
        end else begin : g_rest
            assign prev = row_vals[g-1];
        end
        sc_regscroll_row #(
            .REG_WIDTH (REG_WIDTH)
        ) u_row (
            .clk_i      (SC_RegSCROLL_CLOCK_50),
            .resetn_i   (SC_RegSCROLL_RESET_InLow),
            .clear_i    (SC_RegSCROLL_clear_InHigh),
            .load_i     (row_load[g]),
            .sel_data_i (row_sel[g]),
            .data_i     (SC_RegSCROLL_data_InBUS),
            .prev_i     (prev),
            .q_o        (row_vals[g])
        );
    end

    // Read mux over pre-edge row contents; unmapped addresses read as zero
    always_comb begin
        rddata_d = '0;
        for (int i = 0; i < REG_DEPTH; i++) begin
            if (SC_RegSCROLL_rdaddr_InBUS == ADDR_WIDTH'(i)) begin
                rddata_d = row_vals[i];
            end
        end
    end

    // Read data, spill row, spill strobe and scroll counter; clear leaves the last spill visible
    always_ff @(posedge SC_RegSCROLL_CLOCK_50) begin
        if (!SC_RegSCROLL_RESET_InLow) begin
            rddata_q      <= '0;
            spill_q       <= '0;
            spill_valid_q <= 1'b0;
            count_q       <= '0;
        end else if (SC_RegSCROLL_clear_InHigh) begin
            rddata_q      <= '0;
            spill_valid_q <= 1'b0;
            count_q       <= '0;
        end else begin
            rddata_q      <= rddata_d;
            spill_valid_q <= op_scroll;
            if (op_scroll) begin
                spill_q <= row_vals[REG_DEPTH-1];
            end
            if (op_scroll || op_rotate) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign SC_RegSCROLL_rddata_OutBUS       = rddata_q;
    assign SC_RegSCROLL_spill_OutBUS        = spill_q;
    assign SC_RegSCROLL_spill_valid_OutHigh = spill_valid_q;
    assign SC_RegSCROLL_count_OutBUS        = count_q;

endmodule

// File: tb/tb_sc_reg_scroll_bank.sv
// tb/tb_sc_reg_scroll_bank.sv - directed self-checking bench for sc_reg_scroll_bank
module tb_sc_reg_scroll_bank;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clear;
    logic [1:0] op;
    logic [3:0] wraddr;
    logic [7:0] data;
    logic [3:0] rdaddr;
    logic [7:0] rddata;
    logic [7:0] spill;
    logic       spill_valid;
    logic [7:0] count;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    sc_reg_scroll_bank #(
        .REG_WIDTH  (8),
        .REG_DEPTH  (8),
        .ADDR_WIDTH (4),
        .CNT_WIDTH  (8)
    ) dut (
        .SC_RegSCROLL_CLOCK_50            (clk),
        .SC_RegSCROLL_RESET_InLow         (resetn),
        .SC_RegSCROLL_clear_InHigh        (clear),
        .SC_RegSCROLL_op_InBUS            (op),
        .SC_RegSCROLL_wraddr_InBUS        (wraddr),
        .SC_RegSCROLL_data_InBUS          (data),
        .SC_RegSCROLL_rdaddr_InBUS        (rdaddr),
        .SC_RegSCROLL_rddata_OutBUS       (rddata),
        .SC_RegSCROLL_spill_OutBUS        (spill),
        .SC_RegSCROLL_spill_valid_OutHigh (spill_valid),
        .SC_RegSCROLL_count_OutBUS        (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
        op     = 2'b00;
        rdaddr = 4'(addr);
        tick();
        check(tag, {24'd0, rddata}, {24'd0, exp});
    endtask

    task automatic write_row(input int addr, input logic [7:0] val);
        op     = 2'b01;
        wraddr = 4'(addr);
        data   = val;
        tick();
        op = 2'b00;
    endtask

    initial begin
        logic [7:0] exp_rows [8];

        resetn = 1'b0;
        clear  = 1'b0;
        op     = 2'b01;
        wraddr = 4'd0;
        data   = 8'hFF;
        rdaddr = 4'd0;
        #2;
        tick();
        tick();
        check("reset_rddata", {24'd0, rddata}, 32'd0);
        check("reset_spill", {24'd0, spill}, 32'd0);
        check("reset_spill_valid", {31'd0, spill_valid}, 32'd0);
        check("reset_count", {24'd0, count}, 32'd0);
        resetn = 1'b1;
        op     = 2'b00;
        for (int i = 0; i < 8; i++) read_chk("reset_row", i, 8'h00);

        // fill 0x11..0x88
        for (int i = 0; i < 8; i++) write_row(i, 8'((i + 1) * 8'h11));
        for (int i = 0; i < 8; i++) read_chk("write_row", i, 8'((i + 1) * 8'h11));

        // read-during-write returns old value, then new value
        op = 2'b01; wraddr = 4'd2; data = 8'h5A; rdaddr = 4'd2;
        tick();
        check("rdw_old", {24'd0, rddata}, 32'h33);
        op = 2'b00;
        tick();
        check("rdw_new", {24'd0, rddata}, 32'h5A);
        write_row(2, 8'h33);

        // single scroll
        op = 2'b10; data = 8'hA5; rdaddr = 4'd7;
        tick();
        exp_cnt = 1;
        check("scroll_pre_read", {24'd0, rddata}, 32'h88);
        check("scroll_spill", {24'd0, spill}, 32'h88);
        check("scroll_valid", {31'd0, spill_valid}, 32'd1);
        check("scroll_count", {24'd0, count}, 32'(exp_cnt));
        op = 2'b00;
        tick();
        check("spill_valid_drop", {31'd0, spill_valid}, 32'd0);
        check("spill_hold", {24'd0, spill}, 32'h88);
        read_chk("scroll_row0", 0, 8'hA5);
        read_chk("scroll_row1", 1, 8'h11);
        read_chk("scroll_row7", 7, 8'h77);

        // back-to-back scrolls
        op = 2'b10; data = 8'h01;
        tick();
        check("b2b_spill0", {24'd0, spill}, 32'h77);
        check("b2b_valid0", {31'd0, spill_valid}, 32'd1);
        data = 8'h02;
        tick();
        exp_cnt = 3;
        check("b2b_spill1", {24'd0, spill}, 32'h66);
        check("b2b_valid1", {31'd0, spill_valid}, 32'd1);
        check("b2b_count", {24'd0, count}, 32'(exp_cnt));
        op = 2'b00;
        tick();
        check("b2b_valid_end", {31'd0, spill_valid}, 32'd0);

        // rotate on a fresh 0x11..0x88 bank
        for (int i = 0; i < 8; i++) write_row(i, 8'((i + 1) * 8'h11));
        op = 2'b11; data = 8'hFF;
        tick();
        op = 2'b00;
`ifdef SC_REGSCROLL_ROTATE_EN
        exp_cnt = 4;
        for (int i = 0; i < 8; i++) exp_rows[i] = 8'((((i + 7) % 8) + 1) * 8'h11);
`else
        for (int i = 0; i < 8; i++) exp_rows[i] = 8'((i + 1) * 8'h11);
`endif
        check("rotate_valid", {31'd0, spill_valid}, 32'd0);
        check("rotate_spill", {24'd0, spill}, 32'h66);
        check("rotate_count", {24'd0, count}, 32'(exp_cnt));
        for (int i = 0; i < 8; i++) read_chk("rotate_row", i, exp_rows[i]);

        // counter wrap
        op = 2'b10; data = 8'h00;
        for (int n = exp_cnt; n < 255; n++) tick();
        check("count_255", {24'd0, count}, 32'd255);
        tick();
        check("count_wrap", {24'd0, count}, 32'd0);
        tick();
        check("count_after_wrap", {24'd0, count}, 32'd1);

        // clear with a scroll pending
        for (int i = 0; i < 8; i++) write_row(i, 8'((i + 1) * 8'h11));
        op = 2'b10; data = 8'hFF; clear = 1'b1; rdaddr = 4'd3;
        tick();
        clear = 1'b0;
        op    = 2'b00;
        check("clear_count", {24'd0, count}, 32'd0);
        check("clear_valid", {31'd0, spill_valid}, 32'd0);
        check("clear_rddata", {24'd0, rddata}, 32'd0);
        for (int i = 0; i < 8; i++) read_chk("clear_row", i, 8'h00);

        // out-of-range write and read
        write_row(9, 8'hEE);
        for (int i = 0; i < 8; i++) read_chk("oor_write_row", i, 8'h00);
        write_row(5, 8'h3C);
        read_chk("oor_read", 9, 8'h00);
        read_chk("row5_back", 5, 8'h3C);

        // reset mid-sequence discards the scroll in that cycle
        op = 2'b10; data = 8'h99; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        op     = 2'b00;
        check("midreset_count", {24'd0, count}, 32'd0);
        check("midreset_valid", {31'd0, spill_valid}, 32'd0);
        check("midreset_spill", {24'd0, spill}, 32'd0);
        read_chk("midreset_row0", 0, 8'h00);
        read_chk("midreset_row5", 5, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
